game_ctrl_fsm: RTL and testbench
================================

Name: game_ctrl_fsm

Overview:
- Next-generation game controller FSM for the Minesweeper top level.
- Selects one of NUM_LEVELS difficulty presets and latches the board setup, which drives the board/draw, mine-placement and timer-display paths.
- Owns the countdown timer (timeout forces a loss) and saturating won/lost statistics.
- Adds explicit start/end pulses, a timeout loss and per-game loss cause, none of which the current controller provides.

Parameters:
- NUM_LEVELS, 3, number of selectable presets; valid level codes are 1..NUM_LEVELS.
- LEVEL_W, $clog2(NUM_LEVELS+1), width of the level input.
- TICKS_PER_SEC, 65_000_000, clk cycles per countdown second.
- TIMER_W, 10, width of the seconds counter.
- STAT_W, 8, width of each statistics counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- level  in  LEVEL_W  requested level; 0 = none
- timer_stop  in  1  pause request (level-sensitive)
- game_won  in  1  board-cleared strobe
- game_lost  in  1  mine-hit strobe
- retry  in  1  return-to-menu request
- state  out  state_t  current FSM state
- setup  out  game_setup_t  latched setup: row_column_number, mine_number, field_size, board_size, board_xpos, board_ypos
- seconds_left  out  TIMER_W  remaining seconds
- games_won  out  STAT_W  saturating win count
- games_lost  out  STAT_W  saturating loss count (timeouts included)
- game_start  out  1  one-cycle pulse on LOAD->PLAY
- game_end  out  1  one-cycle pulse on entry to WIN or LOST
- lost_by_timeout  out  1  1 if the last loss came from timer expiry

Behaviour:
- Reset (rst_n=0 at posedge clk): state=MENU; setup='0; seconds_left=0; games_won=0; games_lost=0; all pulses 0; lost_by_timeout=0; prescaler=0.
- All outputs are registered.
- States: MENU, LOAD, PLAY, PAUSE, WIN, LOST, GAME_OVER.
- MENU:
  - setup held at '0.
  - If 1<=level<=NUM_LEVELS: go to LOAD and capture the level index.
  - level=0 or level>NUM_LEVELS: stay in MENU.
- LOAD (exactly 1 cycle):
  - setup <= level_setup(idx); seconds_left <= preset timer_seconds; prescaler cleared; lost_by_timeout cleared.
  - Next state PLAY; game_start=1 in the cycle PLAY is first visible.
- PLAY, priority highest first:
  1. timer_stop -> PAUSE
  2. game_won -> WIN
  3. game_lost -> LOST
  4. timeout -> LOST with lost_by_timeout=1
  - Timeout is defined as: seconds_left==0, or a tick decrementing it 1->0.
  - Prescaler counts 0..TICKS_PER_SEC-1 in PLAY only. On wrap, seconds_left decrements and never goes below 0.
- PAUSE:
  - Prescaler and seconds_left frozen; game_won and game_lost ignored.
  - ~timer_stop -> PLAY, with the prescaler resuming from its held value.
- WIN: games_won += 1, saturating at 2^STAT_W-1; game_end=1; next GAME_OVER.
- LOST: games_lost += 1, saturating; game_end=1; next GAME_OVER.
- GAME_OVER:
  - setup and seconds_left held.
  - retry -> MENU; setup returns to '0 on the first MENU cycle.
- Simultaneous events:
  - game_won with game_lost or timeout: the win is taken.
  - timer_stop with game_won: pause is taken, and the win strobe is lost. The source must re-assert game_won.
- level changes outside MENU are ignored.
- retry outside GAME_OVER is ignored.
- Statistics survive retry and are cleared only by reset.
- Reset mid-game: full reset values in the next cycle, regardless of state.
- Undefined state encoding: go to MENU.

Decomposition:
- game_pkg holds:
  - state_t, including the new LOAD state
  - game_setup_t
  - per-level constants E_/M_/H_*
  - function level_setup(idx) returning game_setup_t, '0 for an invalid idx
- Sub-module sec_countdown (prescaler + down-counter):
  - Inputs: load, load_val, run.
  - Outputs: seconds, zero, tick.

Test Plan:
- Sim with TICKS_PER_SEC=4, E_TIMER_SECONDS=3 for the timeout run.
- Basic win: rst_n low 2 cycles -> all outputs 0, state=MENU. level=1 -> LOAD, then PLAY with game_start=1 and setup=E_* presets. game_won pulse -> WIN (game_end=1, games_won=1), then GAME_OVER. retry -> MENU with setup='0.
- Timeout: level=1, no strobes -> seconds_left reads 3,2,1,0 at 4-cycle spacing. LOST on the tick reaching 0; lost_by_timeout=1; games_lost=1.
- Pause: timer_stop high for 10 cycles in PLAY -> seconds_left and prescaler frozen; game_lost during the pause ignored. Release -> PLAY resumes the count exactly.
- Collision and invalid level: game_won and game_lost in the same cycle -> WIN only. level=NUM_LEVELS+... an invalid code (e.g. 0 or above NUM_LEVELS) in MENU -> state stays MENU.
- Saturation: STAT_W=2; force 5 losses via retry loops -> games_lost=3 and holds.
- Mid-game reset: rst_n low in PLAY -> next cycle MENU, seconds_left=0, stats 0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: controller states, board setup record and per-level presets
package game_pkg;

   typedef enum logic [2:0] {MENU, LOAD, PLAY, PAUSE, WIN, LOST, GAME_OVER} state_t;

   typedef struct packed {
      logic [4:0] row_column_number;
      logic [6:0] mine_number;
      logic [5:0] field_size;
      logic [9:0] board_size;
      logic [9:0] board_xpos;
      logic [9:0] board_ypos;
   } game_setup_t;

   localparam int E_ROW_COLUMN_NUMBER = 9;
   localparam int E_MINE_NUMBER       = 10;
   localparam int E_FIELD_SIZE        = 32;
   localparam int E_BOARD_SIZE        = 288;
   localparam int E_BOARD_XPOS        = 176;
   localparam int E_BOARD_YPOS        = 96;
   localparam int E_TIMER_SECONDS     = 300;

   localparam int M_ROW_COLUMN_NUMBER = 16;
   localparam int M_MINE_NUMBER       = 40;
   localparam int M_FIELD_SIZE        = 24;
   localparam int M_BOARD_SIZE        = 384;
   localparam int M_BOARD_XPOS        = 128;
   localparam int M_BOARD_YPOS        = 48;
   localparam int M_TIMER_SECONDS     = 600;

   localparam int H_ROW_COLUMN_NUMBER = 24;
   localparam int H_MINE_NUMBER       = 99;
   localparam int H_FIELD_SIZE        = 16;
   localparam int H_BOARD_SIZE        = 384;
   localparam int H_BOARD_XPOS        = 128;
   localparam int H_BOARD_YPOS        = 48;
   localparam int H_TIMER_SECONDS     = 999;

   function automatic game_setup_t mk_setup(input int rc, input int mn, input int fs,
                                            input int bs, input int x, input int y);
      return '{5'(rc), 7'(mn), 6'(fs), 10'(bs), 10'(x), 10'(y)};
   endfunction

   // level codes are 1-based; anything else yields an empty setup
   function automatic game_setup_t level_setup(input int idx);
      game_setup_t s;
      s = '0;
      case (idx)
         1: s = mk_setup(E_ROW_COLUMN_NUMBER, E_MINE_NUMBER, E_FIELD_SIZE, E_BOARD_SIZE, E_BOARD_XPOS, E_BOARD_YPOS);
         2: s = mk_setup(M_ROW_COLUMN_NUMBER, M_MINE_NUMBER, M_FIELD_SIZE, M_BOARD_SIZE, M_BOARD_XPOS, M_BOARD_YPOS);
         3: s = mk_setup(H_ROW_COLUMN_NUMBER, H_MINE_NUMBER, H_FIELD_SIZE, H_BOARD_SIZE, H_BOARD_XPOS, H_BOARD_YPOS);
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sec_countdown.sv
// sec_countdown: clock prescaler driving a non-negative seconds down-counter
module sec_countdown #(
   parameter int TICKS = 65_000_000,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         run,
   output logic [W-1:0] seconds,
   output logic         zero,
   output logic         tick
);
   localparam int PW = TICKS > 1 ? $clog2(TICKS) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICKS - 1);

   logic [PW-1:0] presc;

   assign tick = run && presc == PMAX;
   assign zero = seconds == '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc   <= '0;
         seconds <= '0;
      end else if (load) begin
         presc   <= '0;
         seconds <= load_val;
      end else if (run) begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick && !zero) seconds <= seconds - W'(1);
      end
   end

endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: Minesweeper game controller with level presets, countdown and win/loss statistics
module game_ctrl_fsm
   import game_pkg::*;
#(
   parameter int NUM_LEVELS    = 3,
   parameter int LEVEL_W       = $clog2(NUM_LEVELS + 1),
   parameter int TICKS_PER_SEC = 65_000_000,
   parameter int TIMER_W       = 10,
   parameter int STAT_W        = 8,
   parameter int SECS_E        = E_TIMER_SECONDS,
   parameter int SECS_M        = M_TIMER_SECONDS,
   parameter int SECS_H        = H_TIMER_SECONDS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LEVEL_W-1:0] level,
   input  logic               timer_stop,
   input  logic               game_won,
   input  logic               game_lost,
   input  logic               retry,
   output state_t             state,
   output game_setup_t        setup,
   output logic [TIMER_W-1:0] seconds_left,
   output logic [STAT_W-1:0]  games_won,
   output logic [STAT_W-1:0]  games_lost,
   output logic               game_start,
   output logic               game_end,
   output logic               lost_by_timeout
);
   state_t nxt;
   logic [LEVEL_W-1:0] idx;
   logic [TIMER_W-1:0] preset_secs;
   logic level_ok, tick, zero, timeout;

   assign level_ok    = level != '0 && int'(level) <= NUM_LEVELS;
   assign timeout     = zero || (tick && seconds_left == TIMER_W'(1));
   assign preset_secs = TIMER_W'(int'(idx) == 1 ? SECS_E : int'(idx) == 2 ? SECS_M : int'(idx) == 3 ? SECS_H : 0);

   sec_countdown #(.TICKS(TICKS_PER_SEC), .W(TIMER_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == LOAD),
      .load_val (preset_secs),
      .run      (state == PLAY),
      .seconds  (seconds_left),
      .zero     (zero),
      .tick     (tick)
   );

   // a pause wins over a simultaneous win strobe; a win wins over any loss
   always_comb begin
      nxt = MENU;
      case (state)
         MENU:      nxt = level_ok ? LOAD : MENU;
         LOAD:      nxt = PLAY;
         PLAY:      nxt = timer_stop ? PAUSE : game_won ? WIN : (game_lost || timeout) ? LOST : PLAY;
         PAUSE:     nxt = timer_stop ? PAUSE : PLAY;
         WIN, LOST: nxt = GAME_OVER;
         GAME_OVER: nxt = retry ? MENU : GAME_OVER;
         default:   nxt = MENU;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= MENU;
         setup           <= '0;
         idx             <= '0;
         games_won       <= '0;
         games_lost      <= '0;
         game_start      <= 1'b0;
         game_end        <= 1'b0;
         lost_by_timeout <= 1'b0;
      end else begin
         state      <= nxt;
         setup      <= nxt == MENU ? '0 : state == LOAD ? level_setup(int'(idx)) : setup;
         game_start <= state == LOAD;
         game_end   <= state == PLAY && (nxt == WIN || nxt == LOST);
         if (state == MENU) idx <= level;
         if (state == PLAY && nxt == WIN && games_won != '1) games_won <= games_won + STAT_W'(1);
         if (state == PLAY && nxt == LOST && games_lost != '1) games_lost <= games_lost + STAT_W'(1);
         lost_by_timeout <= state == LOAD ? 1'b0 : (state == PLAY && nxt == LOST) ? !game_lost : lost_by_timeout;
      end
   end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb_game_ctrl_fsm: directed vector table plus timeout, pause, saturation and reset sequences
module tb_game_ctrl_fsm;
   import game_pkg::*;

   logic clk = 1'b0;
   logic rst_n, timer_stop, game_won, game_lost, retry;
   logic [1:0] level;
   state_t state;
   game_setup_t setup;
   logic [9:0] seconds_left;
   logic [1:0] games_won, games_lost;
   logic game_start, game_end, lost_by_timeout;
   int tests = 0;
   int fails = 0;

   // input packing: {rst_n, level[1:0], timer_stop, game_won, game_lost, retry}
   localparam logic [6:0] RST     = 7'b0_00_0000;
   localparam logic [6:0] IDLE    = 7'b1_00_0000;
   localparam logic [6:0] L1      = 7'b1_01_0000;
   localparam logic [6:0] L2      = 7'b1_10_0000;
   localparam logic [6:0] L3      = 7'b1_11_0000;
   localparam logic [6:0] TS      = 7'b1_00_1000;
   localparam logic [6:0] TS_WON  = 7'b1_00_1100;
   localparam logic [6:0] TS_LOSE = 7'b1_00_1010;
   localparam logic [6:0] WON     = 7'b1_00_0100;
   localparam logic [6:0] LOSE    = 7'b1_00_0010;
   localparam logic [6:0] BOTH    = 7'b1_00_0110;
   localparam logic [6:0] RETRY   = 7'b1_00_0001;

   always #5 clk = ~clk;

   game_ctrl_fsm #(
      .NUM_LEVELS(3), .TICKS_PER_SEC(4), .TIMER_W(10), .STAT_W(2),
      .SECS_E(3), .SECS_M(5), .SECS_H(7)
   ) dut (
      .clk(clk), .rst_n(rst_n), .level(level), .timer_stop(timer_stop),
      .game_won(game_won), .game_lost(game_lost), .retry(retry),
      .state(state), .setup(setup), .seconds_left(seconds_left),
      .games_won(games_won), .games_lost(games_lost), .game_start(game_start),
      .game_end(game_end), .lost_by_timeout(lost_by_timeout)
   );

   typedef struct {
      logic [6:0] in;
      state_t     st;
      int         secs;
      logic [2:0] fl;
      int         won;
      int         lost;
      int         su;
   } vec_t;

   vec_t v [$];

   function automatic vec_t mk(logic [6:0] in, state_t st, int secs, logic [2:0] fl, int won, int lost, int su);
      vec_t r;
      r.in = in; r.st = st; r.secs = secs; r.fl = fl; r.won = won; r.lost = lost; r.su = su;
      return r;
   endfunction

   function automatic game_setup_t exp_setup(int k);
      game_setup_t s;
      s = '0;
      if (k == 1) s = '{5'd9, 7'd10, 6'd32, 10'd288, 10'd176, 10'd96};
      if (k == 2) s = '{5'd16, 7'd40, 6'd24, 10'd384, 10'd128, 10'd48};
      if (k == 3) s = '{5'd24, 7'd99, 6'd16, 10'd384, 10'd128, 10'd48};
      return s;
   endfunction

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_setup(string name, int k);
      tests++;
      if (setup !== exp_setup(k)) begin
         fails++;
         $display("FAIL %s setup: got %h, expected %h", name, setup, exp_setup(k));
      end
   endtask

   task automatic step(logic [6:0] in);
      {rst_n, level, timer_stop, game_won, game_lost, retry} = in;
      @(posedge clk);
      #1;
   endtask

   // fl = {game_start, game_end, lost_by_timeout}; secs < 0 means not checked
   task automatic chk_out(string tag, state_t st, int secs, logic [2:0] fl, int won, int lost);
      chk({tag, " state"}, int'(state), int'(st));
      if (secs >= 0) chk({tag, " seconds_left"}, int'(seconds_left), secs);
      chk({tag, " start/end/timeout"}, int'({game_start, game_end, lost_by_timeout}), int'(fl));
      chk({tag, " games_won"}, int'(games_won), won);
      chk({tag, " games_lost"}, int'(games_lost), lost);
   endtask

   initial begin
      v.push_back(mk(RST,    MENU,      0, 3'b000, 0, 0, 0));
      v.push_back(mk(RST,    MENU,      0, 3'b000, 0, 0, 0));
      v.push_back(mk(IDLE,   MENU,      0, 3'b000, 0, 0, 0));
      v.push_back(mk(L1,     LOAD,      0, 3'b000, 0, 0, 0));
      v.push_back(mk(IDLE,   PLAY,      3, 3'b100, 0, 0, 1));
      v.push_back(mk(WON,    WIN,       3, 3'b010, 1, 0, 1));
      v.push_back(mk(IDLE,   GAME_OVER, 3, 3'b000, 1, 0, 1));
      v.push_back(mk(L2,     GAME_OVER, 3, 3'b000, 1, 0, 1));
      v.push_back(mk(RETRY,  MENU,     -1, 3'b000, 1, 0, 0));
      v.push_back(mk(IDLE,   MENU,     -1, 3'b000, 1, 0, 0));
      v.push_back(mk(L1,     LOAD,     -1, 3'b000, 1, 0, 0));
      v.push_back(mk(IDLE,   PLAY,      3, 3'b100, 1, 0, 1));
      v.push_back(mk(BOTH,   WIN,       3, 3'b010, 2, 0, 1));
      v.push_back(mk(IDLE,   GAME_OVER, 3, 3'b000, 2, 0, 1));
      v.push_back(mk(RETRY,  MENU,     -1, 3'b000, 2, 0, 0));
      v.push_back(mk(BOTH,   MENU,     -1, 3'b000, 2, 0, 0));
      v.push_back(mk(RETRY,  MENU,     -1, 3'b000, 2, 0, 0));
      v.push_back(mk(L3,     LOAD,     -1, 3'b000, 2, 0, 0));
      v.push_back(mk(IDLE,   PLAY,      7, 3'b100, 2, 0, 3));
      v.push_back(mk(TS_WON, PAUSE,     7, 3'b000, 2, 0, 3));
      v.push_back(mk(TS,     PAUSE,     7, 3'b000, 2, 0, 3));
      v.push_back(mk(IDLE,   PLAY,      7, 3'b000, 2, 0, 3));
      v.push_back(mk(LOSE,   LOST,      7, 3'b010, 2, 1, 3));
      v.push_back(mk(IDLE,   GAME_OVER, 7, 3'b000, 2, 1, 3));
      v.push_back(mk(RETRY,  MENU,     -1, 3'b000, 2, 1, 0));

      foreach (v[i]) begin
         step(v[i].in);
         chk_out($sformatf("vec%0d", i), v[i].st, v[i].secs, v[i].fl, v[i].won, v[i].lost);
         chk_setup($sformatf("vec%0d", i), v[i].su);
      end

      // timeout: 3 s at 4 cycles per second, loss lands on the tick reaching 0
      step(L1);
      chk_out("to load", LOAD, -1, 3'b000, 2, 1);
      step(IDLE);
      chk_out("to c1", PLAY, 3, 3'b100, 2, 1);
      chk_setup("to c1", 1);
      for (int c = 2; c <= 12; c++) begin
         step(IDLE);
         chk_out($sformatf("to c%0d", c), PLAY, 3 - (c - 1) / 4, 3'b000, 2, 1);
      end
      step(IDLE);
      chk_out("to lost", LOST, 0, 3'b011, 2, 2);
      step(IDLE);
      chk_out("to over", GAME_OVER, 0, 3'b001, 2, 2);
      step(RETRY);
      chk_out("to menu", MENU, -1, 3'b001, 2, 2);
      chk_setup("to menu", 0);

      // pause: ten cycles of timer_stop with loss strobes, count resumes where it stopped
      step(L1);
      step(IDLE);
      chk_out("pz c1", PLAY, 3, 3'b100, 2, 2);
      step(IDLE);
      step(IDLE);
      chk_out("pz c3", PLAY, 3, 3'b000, 2, 2);
      step(TS);
      chk_out("pz enter", PAUSE, 3, 3'b000, 2, 2);
      for (int i = 0; i < 9; i++) begin
         step(TS_LOSE);
         chk_out($sformatf("pz hold%0d", i), PAUSE, 3, 3'b000, 2, 2);
      end
      step(IDLE);
      chk_out("pz resume", PLAY, 3, 3'b000, 2, 2);
      step(IDLE);
      chk_out("pz tick", PLAY, 2, 3'b000, 2, 2);
      for (int i = 0; i < 3; i++) begin
         step(IDLE);
         chk_out($sformatf("pz run%0d", i), PLAY, 2, 3'b000, 2, 2);
      end
      step(IDLE);
      chk_out("pz tick2", PLAY, 1, 3'b000, 2, 2);
      step(LOSE);
      chk_out("pz lost", LOST, 1, 3'b010, 2, 3);
      step(IDLE);

      // saturation: two further losses keep games_lost at 3
      for (int k = 0; k < 2; k++) begin
         step(RETRY);
         step(L2);
         step(IDLE);
         chk_out($sformatf("sat%0d play", k), PLAY, 5, 3'b100, 2, 3);
         chk_setup($sformatf("sat%0d play", k), 2);
         step(LOSE);
         chk_out($sformatf("sat%0d lost", k), LOST, 5, 3'b010, 2, 3);
         step(IDLE);
         chk_out($sformatf("sat%0d over", k), GAME_OVER, 5, 3'b000, 2, 3);
      end

      // reset in the middle of a game
      step(RETRY);
      step(L1);
      step(IDLE);
      step(IDLE);
      chk_out("mr play", PLAY, 3, 3'b000, 2, 3);
      step(RST);
      chk_out("mr reset", MENU, 0, 3'b000, 0, 0);
      chk_setup("mr reset", 0);
      step(IDLE);
      chk_out("mr menu", MENU, 0, 3'b000, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
